ctrl_pkt_gen: RTL and testbench



---
 rtl/ctrl_pkt_gen.sv | 176 +++++++++++++++++
 tb/tb_ctrl_pkt_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pkt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkt_gen
//  Description : Control-path packet transmitter. Converts one table-write
//                request into a two-beat AXI-Stream control packet on the
//                512-bit control bus (beat 0 = header, beat 1 = payload).
//  Ports       : axis_clk / areset      - clock, sync active-high reset
//                req_*                  - write request (valid/ready)
//                c_m_axis_*             - AXI-Stream master (control bus)
//                pkt_cnt                - packets fully sent (wraps)
//                drop_cnt               - requests dropped for bad stage ID
//                                         (saturates)
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pkt_gen #(
  parameter int         C_S_AXIS_DATA_WIDTH  = 512,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int         NUM_STAGES           = 5,
  parameter logic [7:0] SRC_PORT             = 8'h01,
  parameter logic [7:0] DST_PORT             = 8'h00
) (
  input  logic                                axis_clk,
  input  logic                                areset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [4:0]                          req_stage_id,
  input  logic [2:0]                          req_module_id,
  input  logic [7:0]                          req_addr,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      req_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
  output logic [(C_S_AXIS_DATA_WIDTH/8)-1:0]  c_m_axis_tkeep,
  output logic                                c_m_axis_tvalid,
  output logic                                c_m_axis_tlast,
  input  logic                                c_m_axis_tready,
  output logic [31:0]                         pkt_cnt,
  output logic [15:0]                         drop_cnt
);

  localparam int          c_keep_w     = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [5:0]  c_num_stages = 6'(NUM_STAGES);
  localparam logic [7:0]  c_marker     = 8'hA5;
  localparam logic [15:0] c_pkt_len    = 16'd128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2
  } state_t;

  state_t                            state_q,     state_d;
  logic                              req_ready_q, req_ready_d;
  logic                              tvalid_q,    tvalid_d;
  logic                              tlast_q,     tlast_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    tdata_q,     tdata_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser_q,     tuser_d;
  logic [c_keep_w-1:0]               tkeep_q,     tkeep_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    hold_data_q, hold_data_d;
  logic [7:0]                        seq_q,       seq_d;
  logic [31:0]                       pkt_cnt_q,   pkt_cnt_d;
  logic [15:0]                       drop_cnt_q,  drop_cnt_d;

  logic w_accept;
  logic w_stage_ok;

  assign w_accept   = req_valid && req_ready_q;
  assign w_stage_ok = ({1'b0, req_stage_id} < c_num_stages);

  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    tuser_d     = tuser_q;
    tkeep_d     = tkeep_q;
    hold_data_d = hold_data_q;
    seq_d       = seq_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_stage_ok) begin
            // Header fields go straight into the output register; only the
            // payload must be held until the header beat is taken.
            hold_data_d         = req_data;
            tdata_d             = '0;
            tdata_d[31:0]       = {c_marker, seq_q, req_addr, req_stage_id, req_module_id};
            tuser_d             = '0;
            tuser_d[31:0]       = {DST_PORT, SRC_PORT, c_pkt_len};
            tkeep_d             = '1;
            tvalid_d            = 1'b1;
            tlast_d             = 1'b0;
            state_d             = S_HDR;
          end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end

      S_HDR: begin
        if (c_m_axis_tready) begin
          tdata_d = hold_data_q;
          tuser_d = '0;
          tlast_d = 1'b1;
          state_d = S_PAY;
        end
      end

      S_PAY: begin
        if (c_m_axis_tready) begin
          tvalid_d  = 1'b0;
          tlast_d   = 1'b0;
          tdata_d   = '0;
          tuser_d   = '0;
          tkeep_d   = '0;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          seq_d     = seq_q + 8'd1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        tuser_d  = '0;
        tkeep_d  = '0;
        state_d  = S_IDLE;
      end
    endcase

    // Registered ready: high exactly when the FSM will sit in IDLE next cycle.
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= '0;
      tkeep_q     <= '0;
      hold_data_q <= '0;
      seq_q       <= 8'd0;
      pkt_cnt_q   <= 32'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tkeep_q     <= tkeep_d;
      hold_data_q <= hold_data_d;
      seq_q       <= seq_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign c_m_axis_tdata  = tdata_q;
  assign c_m_axis_tuser  = tuser_q;
  assign c_m_axis_tkeep  = tkeep_q;
  assign c_m_axis_tvalid = tvalid_q;
  assign c_m_axis_tlast  = tlast_q;
  assign pkt_cnt         = pkt_cnt_q;
  assign drop_cnt        = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pkt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pkt_gen
//  Description : Directed self-checking bench for ctrl_pkt_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pkt_gen;

  localparam logic [127:0] EXP_TUSER_HDR = 128'h0001_0080;

  logic         axis_clk = 1'b0;
  logic         areset;
  logic         req_valid;
  logic         req_ready;
  logic [4:0]   req_stage_id;
  logic [2:0]   req_module_id;
  logic [7:0]   req_addr;
  logic [511:0] req_data;
  logic [511:0] c_m_axis_tdata;
  logic [127:0] c_m_axis_tuser;
  logic [63:0]  c_m_axis_tkeep;
  logic         c_m_axis_tvalid;
  logic         c_m_axis_tlast;
  logic         c_m_axis_tready;
  logic [31:0]  pkt_cnt;
  logic [15:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  ctrl_pkt_gen #(
    .C_S_AXIS_DATA_WIDTH  (512),
    .C_S_AXIS_TUSER_WIDTH (128),
    .NUM_STAGES           (5),
    .SRC_PORT             (8'h01),
    .DST_PORT             (8'h00)
  ) dut (
    .axis_clk        (axis_clk),
    .areset          (areset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_stage_id    (req_stage_id),
    .req_module_id   (req_module_id),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .c_m_axis_tdata  (c_m_axis_tdata),
    .c_m_axis_tuser  (c_m_axis_tuser),
    .c_m_axis_tkeep  (c_m_axis_tkeep),
    .c_m_axis_tvalid (c_m_axis_tvalid),
    .c_m_axis_tlast  (c_m_axis_tlast),
    .c_m_axis_tready (c_m_axis_tready),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    cyc = cyc + 1;
    if (c_m_axis_tvalid && c_m_axis_tready) hs_cnt = hs_cnt + 1;
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_hdr(input logic [4:0] s, input logic [2:0] m,
                                          input logic [7:0] a, input logic [7:0] q);
    logic [511:0] h;
    h = '0;
    h[31:0] = {8'hA5, q, a, s, m};
    return h;
  endfunction

  task automatic check_hdr(input string tag, input logic [511:0] exp_data);
    chk({tag, "_tvalid"},    512'(c_m_axis_tvalid), 512'd1);
    chk({tag, "_tlast"},     512'(c_m_axis_tlast),  512'd0);
    chk({tag, "_tdata"},     c_m_axis_tdata,        exp_data);
    chk({tag, "_tuser"},     512'(c_m_axis_tuser),  512'(EXP_TUSER_HDR));
    chk({tag, "_tkeep"},     512'(c_m_axis_tkeep),  512'(64'hFFFF_FFFF_FFFF_FFFF));
    chk({tag, "_req_ready"}, 512'(req_ready),       512'd0);
  endtask

  task automatic check_pay(input string tag, input logic [511:0] exp_data);
    chk({tag, "_tvalid"},    512'(c_m_axis_tvalid), 512'd1);
    chk({tag, "_tlast"},     512'(c_m_axis_tlast),  512'd1);
    chk({tag, "_tdata"},     c_m_axis_tdata,        exp_data);
    chk({tag, "_tuser"},     512'(c_m_axis_tuser),  512'd0);
    chk({tag, "_tkeep"},     512'(c_m_axis_tkeep),  512'(64'hFFFF_FFFF_FFFF_FFFF));
    chk({tag, "_req_ready"}, 512'(req_ready),       512'd0);
  endtask

  // Present a request, wait (bounded) for ready, complete the handshake.
  task automatic send_req(input logic [4:0] s, input logic [2:0] m,
                          input logic [7:0] a, input logic [511:0] d);
    int k;
    req_stage_id  = s;
    req_module_id = m;
    req_addr      = a;
    req_data      = d;
    req_valid     = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    chk("req_ready_wait", 512'(req_ready), 512'd1);
    tick();
    acc_cyc   = cyc;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] bp_data;
    logic [511:0] d;
    int           hs0;
    int           prev_acc;

    areset          = 1'b1;
    req_valid       = 1'b0;
    req_stage_id    = '0;
    req_module_id   = '0;
    req_addr        = '0;
    req_data        = '0;
    c_m_axis_tready = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_tvalid",    512'(c_m_axis_tvalid), 512'd0);
    chk("rst_tlast",     512'(c_m_axis_tlast),  512'd0);
    chk("rst_tdata",     c_m_axis_tdata,        512'd0);
    chk("rst_tuser",     512'(c_m_axis_tuser),  512'd0);
    chk("rst_tkeep",     512'(c_m_axis_tkeep),  512'd0);
    chk("rst_req_ready", 512'(req_ready),       512'd0);
    chk("rst_pkt_cnt",   512'(pkt_cnt),         512'd0);
    chk("rst_drop_cnt",  512'(drop_cnt),        512'd0);
    areset = 1'b0;
    tick();
    chk("post_rst_req_ready", 512'(req_ready), 512'd1);

    // ---------------- bad stage IDs ----------------
    hs0 = hs_cnt;
    send_req(5'd5, 3'd0, 8'h11, 512'hDEAD);
    chk("drop1_tvalid",    512'(c_m_axis_tvalid), 512'd0);
    chk("drop1_drop_cnt",  512'(drop_cnt),        512'd1);
    chk("drop1_req_ready", 512'(req_ready),       512'd1);
    send_req(5'd31, 3'd7, 8'hFF, '1);
    chk("drop2_drop_cnt",  512'(drop_cnt),        512'd2);
    tick();
    tick();
    chk("drop_tvalid_late", 512'(c_m_axis_tvalid), 512'd0);
    chk("drop_no_hs",       512'(hs_cnt - hs0),    512'd0);
    chk("drop_pkt_cnt",     512'(pkt_cnt),         512'd0);

    // ---------------- single write ----------------
    send_req(5'd2, 3'd3, 8'h07, 512'h1234);
    check_hdr("single_hdr", 512'hA500_0713);
    tick();
    check_pay("single_pay", 512'h1234);
    tick();
    chk("single_done_tvalid", 512'(c_m_axis_tvalid), 512'd0);
    chk("single_done_ready",  512'(req_ready),       512'd1);
    chk("single_pkt_cnt",     512'(pkt_cnt),         512'd1);

    // ---------------- backpressure ----------------
    bp_data = {16{32'h5A5A_F00D}};
    c_m_axis_tready = 1'b0;
    hs0 = hs_cnt;
    send_req(5'd1, 3'd0, 8'h3C, bp_data);
    check_hdr("bp_hdr", 512'hA501_3C08);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_hdr("bp_hdr_stall", 512'hA501_3C08);
    end
    c_m_axis_tready = 1'b1;
    tick();
    c_m_axis_tready = 1'b0;
    check_pay("bp_pay", bp_data);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pay("bp_pay_stall", bp_data);
    end
    c_m_axis_tready = 1'b1;
    tick();
    chk("bp_hs_count", 512'(hs_cnt - hs0),    512'd2);
    chk("bp_tvalid",   512'(c_m_axis_tvalid), 512'd0);
    chk("bp_ready",    512'(req_ready),       512'd1);
    chk("bp_pkt_cnt",  512'(pkt_cnt),         512'd2);

    // ---------------- sequence wrap ----------------
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    chk("wrap_start_pkt_cnt", 512'(pkt_cnt), 512'd0);
    prev_acc = 0;
    for (int i = 1; i <= 257; i++) begin
      d = {480'(i), 32'hCAFE_0000};
      send_req(5'(i % 5), 3'(i % 8), 8'(i), d);
      if (i > 1) chk("wrap_gap", 512'(acc_cyc - prev_acc), 512'd3);
      prev_acc = acc_cyc;
      check_hdr("wrap_hdr", mk_hdr(5'(i % 5), 3'(i % 8), 8'(i), 8'(i - 1)));
      if (i == 256) chk("wrap_seq_ff", 512'(c_m_axis_tdata[23:16]), 512'h0FF);
      if (i == 257) chk("wrap_seq_00", 512'(c_m_axis_tdata[23:16]), 512'h000);
      tick();
      check_pay("wrap_pay", d);
      tick();
    end
    chk("wrap_pkt_cnt", 512'(pkt_cnt), 512'd257);

    // ---------------- reset mid-packet ----------------
    send_req(5'd9, 3'd0, 8'h00, '0);
    chk("mid_drop_cnt", 512'(drop_cnt), 512'd1);
    send_req(5'd4, 3'd2, 8'hAA, {16{32'h0BAD_BEEF}});
    tick();
    c_m_axis_tready = 1'b0;
    tick();
    check_pay("mid_pay_stall", {16{32'h0BAD_BEEF}});
    areset = 1'b1;
    tick();
    chk("mid_rst_tvalid",   512'(c_m_axis_tvalid), 512'd0);
    chk("mid_rst_tlast",    512'(c_m_axis_tlast),  512'd0);
    chk("mid_rst_ready",    512'(req_ready),       512'd0);
    chk("mid_rst_pkt_cnt",  512'(pkt_cnt),         512'd0);
    chk("mid_rst_drop_cnt", 512'(drop_cnt),        512'd0);
    areset = 1'b0;
    c_m_axis_tready = 1'b1;
    hs0 = hs_cnt;
    tick();
    tick();
    chk("mid_no_partial_hs", 512'(hs_cnt - hs0),    512'd0);
    chk("mid_idle_tvalid",   512'(c_m_axis_tvalid), 512'd0);
    chk("mid_idle_ready",    512'(req_ready),       512'd1);
    send_req(5'd0, 3'd1, 8'h55, 512'h77);
    check_hdr("post_rst_hdr", 512'hA500_5501);
    tick();
    check_pay("post_rst_pay", 512'h77);
    tick();
    chk("post_rst_pkt_cnt", 512'(pkt_cnt), 512'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
